xmit_frame_buf: RTL and testbench
=================================

# xmit_frame_buf

Store-and-forward transmit byte buffer that sits directly upstream of the transmit nibble FSM in the Xmit path. It accepts frame bytes from the host-side framer, holds each frame until it is complete, then plays it out as a byte stream paced at one byte per two `clk_phy` cycles, matching the 4-bit nibble output rate. Between frames it enforces the inter-frame gap and reports overflow and underrun.

## Interface
- `DEPTH`, 2048: FIFO entries; power of two; each entry is 9 bits (byte plus EOP flag).
- `IFG_BYTES`, 12: inter-frame gap in byte times.
- `MIN_LEN`, 60: minimum emitted frame length in bytes; only used with padding compiled in.

- `clk_phy`  in  1  single clock for the whole block.
- `reset`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  write one byte this cycle.
- `wr_data`  in  8  byte to write.
- `wr_eop`  in  1  this byte is the last byte of its frame.
- `wr_full`  out  1  FIFO holds `DEPTH` entries.
- `wr_drop`  out  1  one-cycle pulse: a write was discarded because the FIFO was full.
- `data_out`  out  8  byte presented to the nibble FSM `data_in`.
- `tx_en`  out  1  `data_out` carries frame data.
- `nib_phase`  out  1  0 = low-nibble cycle, 1 = high-nibble cycle of the current byte.
- `tx_underrun`  out  1  one-cycle pulse: FIFO ran empty mid-frame.

## Operation
- FIFO:
  - Circular buffer with read and write pointers of log2(`DEPTH`)+1 bits.
  - Full when the pointers differ only in the MSB; empty when they are equal.
  - A write while full and no pop is discarded, and `wr_drop` pulses.
  - A push and a pop in the same cycle while full both take effect.
- `frame_cnt`:
  - Counts complete frames held in the FIFO.
  - Increments on an accepted write with `wr_eop`=1 and decrements when the EOP entry is popped.
  - A simultaneous increment and decrement leaves it unchanged.
- State machine: IDLE, SEND, DRAIN, IFG.
  - IDLE → SEND when `frame_cnt`>0, or when `wr_full`=1 (forced cut-through, which prevents deadlock on an oversize frame).
  - SEND pops one entry per byte time, on the cycle where `nib_phase` goes 1→0 or on SEND entry.
  - SEND → IFG after the EOP byte has completed both nibble cycles (and after padding, when enabled).
  - SEND → DRAIN if a pop is due while the FIFO is empty: `tx_underrun` pulses, and `tx_en` drops immediately.
  - DRAIN discards entries until an EOP entry is popped, then → IFG.
  - IFG holds `tx_en`=0 for `IFG_BYTES`×2 cycles, then → IDLE.
- `nib_phase` toggles every cycle in SEND; it is held at 0 in all other states.
- Byte counter (11 bits) counts emitted bytes in the frame and saturates at 2047.

## Timing
- Reset: all outputs 0, pointers 0, `frame_cnt` 0, state IDLE. Reset takes effect on the next edge, including mid-frame; a partial frame in flight is lost with no underrun pulse.
- `wr_full`, `wr_drop` and `frame_cnt` update one cycle after the write edge.
- Start latency: the first byte appears on `data_out` with `tx_en`=1 two cycles after `frame_cnt` becomes nonzero.
- Each byte is held for exactly 2 cycles (`nib_phase` 0 then 1). An N-byte frame occupies 2N cycles of `tx_en`=1.
- `data_out` = 0x00 whenever `tx_en`=0.
- The next frame's first byte comes no earlier than 2×`IFG_BYTES`+1 cycles after the last `tx_en`=1 cycle.

## Configuration
- `XMIT_PAD_EN` defined: when the EOP byte is emitted with byte count < `MIN_LEN`, SEND continues emitting 0x00 bytes with `tx_en`=1 until `MIN_LEN` bytes total, then → IFG.
- `XMIT_PAD_EN` undefined: frames are emitted at their written length, and `MIN_LEN` is unused.

## Test plan
- Reset, then write a 64-byte frame 0x00..0x3F with EOP on the last byte → `tx_en` high for 128 cycles, bytes in order, `nib_phase` alternating 0/1, then `tx_en` low for ≥24 cycles.
- Two back-to-back 64-byte frames written → second frame starts exactly 25 cycles after the first frame's last `tx_en` cycle, with `IFG_BYTES`=12.
- 20-byte frame: with `XMIT_PAD_EN`, 60 bytes are emitted (bytes 20–59 = 0x00, 120 cycles); without it, 40 cycles of `tx_en`.
- `DEPTH`=16, with 17 writes and no EOP → forced start; 17th write asserts `wr_drop` unless a pop coincided; FIFO empties before EOP → `tx_underrun` pulse, `tx_en` low, remaining bytes drained through EOP.
- Assert `reset` for one cycle during byte 10 of a frame → next cycle `tx_en`=0, `data_out`=0, `wr_full`=0, no transmission until a new complete frame is written.

Source files
------------

// File: rtl/xmit_frame_buf.sv
// Store-and-forward transmit byte buffer feeding the nibble FSM at one byte per two clk_phy cycles.
// Optional zero padding to MIN_LEN is compiled in with `define XMIT_PAD_EN.
module xmit_frame_buf #(
    parameter int unsigned DEPTH     = 2048,
    parameter int unsigned IFG_BYTES = 12,
    parameter int unsigned MIN_LEN   = 60
) (
    input  logic       clk_phy,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       wr_eop,
    output logic       wr_full,
    output logic       wr_drop,
    output logic [7:0] data_out,
    output logic       tx_en,
    output logic       nib_phase,
    output logic       tx_underrun
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam int unsigned IFG_CYC  = 2 * IFG_BYTES;
    // IDLE and the first SEND cycle also hold tx_en low, so the IFG state itself is shorter
    localparam int unsigned IFG_LOAD = (IFG_CYC > 3) ? IFG_CYC - 3 : 0;
    localparam int unsigned IFGW     = $clog2(IFG_CYC + 1) + 1;
    localparam logic [10:0] MIN_CNT  = 11'(MIN_LEN);
`ifdef XMIT_PAD_EN
    localparam logic PAD_ON = 1'b1;
`else
    localparam logic PAD_ON = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, SEND, DRAIN, IFG} state_t;

    state_t            state;
    logic [8:0]        mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [AW:0]       frame_cnt;
    logic              first;
    logic              eop_seen;
    logic [10:0]       byte_cnt;
    logic [IFGW-1:0]   ifg_cnt;

    logic              empty;
    logic              full;
    logic [8:0]        rd_entry;
    logic              pad_more;
    logic              frame_done;
    logic              byte_due;
    logic              pop;
    logic              push;
    logic              eop_push;
    logic              eop_pop;

    always_comb begin
        empty      = (wr_ptr == rd_ptr);
        full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        rd_entry   = mem[rd_ptr[AW-1:0]];
        pad_more   = PAD_ON && (byte_cnt < MIN_CNT);
        frame_done = eop_seen && !pad_more;
        byte_due   = (state == SEND) && (first || nib_phase);
        pop        = (byte_due && !eop_seen && !empty) || ((state == DRAIN) && !empty);
        push       = wr_en && (!full || pop);
        eop_push   = push && wr_eop;
        eop_pop    = pop && rd_entry[8];
    end

    assign wr_full = full;

    always_ff @(posedge clk_phy) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {wr_eop, wr_data};
        end
    end

    always_ff @(posedge clk_phy) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            frame_cnt <= '0;
            wr_drop   <= 1'b0;
        end else begin
            wr_drop <= wr_en && full && !pop;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({eop_push, eop_pop})
                2'b10:   frame_cnt <= frame_cnt + 1'b1;
                2'b01:   frame_cnt <= frame_cnt - 1'b1;
                default: frame_cnt <= frame_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_phy) begin
        if (reset) begin
            state       <= IDLE;
            tx_en       <= 1'b0;
            data_out    <= '0;
            nib_phase   <= 1'b0;
            tx_underrun <= 1'b0;
            first       <= 1'b0;
            eop_seen    <= 1'b0;
            byte_cnt    <= '0;
            ifg_cnt     <= '0;
        end else begin
            tx_underrun <= 1'b0;
            case (state)
                IDLE: begin
                    tx_en     <= 1'b0;
                    data_out  <= '0;
                    nib_phase <= 1'b0;
                    // a full FIFO forces cut-through so an oversize frame cannot deadlock
                    if ((frame_cnt != '0) || full) begin
                        state    <= SEND;
                        first    <= 1'b1;
                        eop_seen <= 1'b0;
                        byte_cnt <= '0;
                    end
                end
                SEND: begin
                    if (!byte_due) begin
                        nib_phase <= 1'b1;
                    end else if (frame_done) begin
                        state     <= IFG;
                        tx_en     <= 1'b0;
                        data_out  <= '0;
                        nib_phase <= 1'b0;
                        ifg_cnt   <= IFGW'(IFG_LOAD);
                    end else if (eop_seen) begin
                        tx_en     <= 1'b1;
                        data_out  <= '0;
                        nib_phase <= 1'b0;
                        first     <= 1'b0;
                        byte_cnt  <= (byte_cnt == '1) ? byte_cnt : byte_cnt + 1'b1;
                    end else if (empty) begin
                        state       <= DRAIN;
                        tx_underrun <= 1'b1;
                        tx_en       <= 1'b0;
                        data_out    <= '0;
                        nib_phase   <= 1'b0;
                        first       <= 1'b0;
                    end else begin
                        tx_en     <= 1'b1;
                        data_out  <= rd_entry[7:0];
                        nib_phase <= 1'b0;
                        first     <= 1'b0;
                        eop_seen  <= rd_entry[8];
                        byte_cnt  <= (byte_cnt == '1) ? byte_cnt : byte_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (eop_pop) begin
                        state   <= IFG;
                        ifg_cnt <= IFGW'(IFG_LOAD);
                    end
                end
                IFG: begin
                    if (ifg_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        ifg_cnt <= ifg_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xmit_frame_buf.sv
// Bench for xmit_frame_buf: a queue-based frame model checks the large instance, directed
// cut-through/underrun checks exercise a 16-entry instance. Honours `define XMIT_PAD_EN.
`timescale 1ns/1ps
module tb_xmit_frame_buf;

    localparam int MIN_LEN = 60;
    localparam int IFG_LOW = 24;
`ifdef XMIT_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic       clk_phy = 1'b0;
    logic       reset   = 1'b1;
    logic       wr_en = 1'b0, wr_eop = 1'b0;
    logic [7:0] wr_data = '0;
    logic       wr_full, wr_drop, tx_en, nib_phase, tx_underrun;
    logic [7:0] data_out;
    logic       wr_en_s = 1'b0, wr_eop_s = 1'b0;
    logic [7:0] wr_data_s = '0;
    logic       wr_full_s, wr_drop_s, tx_en_s, nib_phase_s, tx_underrun_s;
    logic [7:0] data_out_s;

    always #5 clk_phy = ~clk_phy;

    xmit_frame_buf #(.DEPTH(2048), .IFG_BYTES(12), .MIN_LEN(MIN_LEN)) dut (
        .clk_phy(clk_phy), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .wr_eop(wr_eop),
        .wr_full(wr_full), .wr_drop(wr_drop), .data_out(data_out), .tx_en(tx_en),
        .nib_phase(nib_phase), .tx_underrun(tx_underrun));

    xmit_frame_buf #(.DEPTH(16), .IFG_BYTES(12), .MIN_LEN(MIN_LEN)) dut_s (
        .clk_phy(clk_phy), .reset(reset), .wr_en(wr_en_s), .wr_data(wr_data_s), .wr_eop(wr_eop_s),
        .wr_full(wr_full_s), .wr_drop(wr_drop_s), .data_out(data_out_s), .tx_en(tx_en_s),
        .nib_phase(nib_phase_s), .tx_underrun(tx_underrun_s));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // reference model: expected output bytes (padding included) and per-frame lengths
    logic [7:0] exp_bytes[$];
    int         exp_len[$];
    logic [7:0] frm[$];
    bit         mon_hold = 1'b0;

    bit         in_run = 1'b0;
    bit         exp_ph = 1'b0;
    int         run_len = 0;
    int         gap = 1000;
    int         last_gap = 0;
    logic [7:0] cur = '0;

    always @(negedge clk_phy) begin
        if (reset || mon_hold) begin
            in_run = 1'b0;
            gap    = 1000;
        end else begin
            check("underrun_main", int'(tx_underrun), 0);
            check("drop_main", int'(wr_drop), 0);
            if (tx_en) begin
                if (!in_run) begin
                    in_run   = 1'b1;
                    run_len  = 0;
                    last_gap = gap;
                    exp_ph   = 1'b0;
                    check("gap_min", int'(gap >= IFG_LOW), 1);
                end
                run_len++;
                check("nib_phase", int'(nib_phase), int'(exp_ph));
                if (!nib_phase) begin
                    if (exp_bytes.size() == 0) begin
                        check("extra_byte", 1, 0);
                    end else begin
                        cur = data_out;
                        check("byte", int'(data_out), int'(exp_bytes.pop_front()));
                    end
                end else begin
                    check("byte_hold", int'(data_out), int'(cur));
                end
                exp_ph = ~exp_ph;
            end else begin
                check("idle_data", int'(data_out), 0);
                check("idle_phase", int'(nib_phase), 0);
                if (in_run) begin
                    in_run = 1'b0;
                    gap    = 0;
                    if (exp_len.size() == 0) check("extra_frame", 1, 0);
                    else check("frame_cycles", run_len, 2 * exp_len.pop_front());
                end
                gap++;
            end
        end
    end

    task automatic wr_main(input logic [7:0] d, input logic e);
        wr_en = 1'b1; wr_data = d; wr_eop = e;
        @(posedge clk_phy); #1;
        wr_en = 1'b0; wr_data = '0; wr_eop = 1'b0;
    endtask

    task automatic wr_small(input logic [7:0] d, input logic e);
        wr_en_s = 1'b1; wr_data_s = d; wr_eop_s = e;
        @(posedge clk_phy); #1;
        wr_en_s = 1'b0; wr_data_s = '0; wr_eop_s = 1'b0;
    endtask

    task automatic send_frame(input int max_gap);
        int n;
        int elen;
        n    = frm.size();
        elen = (PAD && n < MIN_LEN) ? MIN_LEN : n;
        for (int i = 0; i < elen; i++) exp_bytes.push_back(i < n ? frm[i] : 8'h00);
        exp_len.push_back(elen);
        for (int i = 0; i < n; i++) begin
            wr_main(frm[i], i == n - 1);
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) begin @(posedge clk_phy); #1; end
        end
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 20000 && exp_len.size() != 0; c++) @(posedge clk_phy);
        #1;
        check("drain", exp_len.size(), 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         idx;
        bit         seen;
        bit         any_tx;
        int         elen;
        int         len;
        logic [7:0] got[$];

        repeat (3) @(posedge clk_phy);
        #1;
        check("rst_tx_en", int'(tx_en), 0);
        check("rst_data", int'(data_out), 0);
        check("rst_full", int'(wr_full), 0);
        check("rst_phase", int'(nib_phase), 0);
        check("rst_s_tx_en", int'(tx_en_s), 0);
        check("rst_s_underrun", int'(tx_underrun_s), 0);
        reset = 1'b0;
        repeat (2) begin @(posedge clk_phy); #1; end

        // 16-entry instance: forced cut-through, drop, underrun and drain
        for (int i = 0; i < 16; i++) wr_small(8'(i), 1'b0);
        check("full_s", int'(wr_full_s), 1);
        wr_small(8'h10, 1'b0);
        check("drop_s", int'(wr_drop_s), 1);
        @(posedge clk_phy); #1;
        check("drop_pulse_s", int'(wr_drop_s), 0);
        idx  = 0;
        seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk_phy);
            if (tx_underrun_s) begin
                check("underrun_txen_s", int'(tx_en_s), 0);
                seen = 1'b1;
                break;
            end
            if (tx_en_s && !nib_phase_s) begin
                check("cut_byte_s", int'(data_out_s), idx);
                idx++;
            end
        end
        check("cut_count_s", idx, 16);
        check("underrun_seen_s", int'(seen), 1);
        @(posedge clk_phy); #1;
        check("underrun_pulse_s", int'(tx_underrun_s), 0);
        wr_small(8'hA0, 1'b0);
        wr_small(8'hA1, 1'b0);
        wr_small(8'hA2, 1'b1);
        any_tx = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk_phy);
            if (tx_en_s) any_tx = 1'b1;
        end
        check("drain_silent_s", int'(any_tx), 0);
        @(posedge clk_phy); #1;
        for (int i = 0; i < 4; i++) wr_small(8'(8'h51 + i), i == 3);
        got.delete();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk_phy);
            if (tx_en_s && !nib_phase_s) got.push_back(data_out_s);
            if (got.size() > 0 && !tx_en_s) break;
        end
        elen = PAD ? MIN_LEN : 4;
        check("post_drain_len_s", got.size(), elen);
        for (int i = 0; i < got.size() && i < elen; i++)
            check("post_drain_byte_s", int'(got[i]), i < 4 ? 8'h51 + i : 0);
        @(posedge clk_phy); #1;

        // 64-byte frame 0x00..0x3F with start-latency check
        frm.delete();
        for (int i = 0; i < 64; i++) frm.push_back(8'(i));
        send_frame(0);
        @(posedge clk_phy); #1;
        check("latency_1", int'(tx_en), 0);
        @(posedge clk_phy); #1;
        check("latency_2", int'(tx_en), 1);
        check("latency_byte", int'(data_out), 0);
        wait_drain();

        // two back-to-back frames: inter-frame gap is exactly 24 low cycles
        frm.delete();
        for (int i = 0; i < 64; i++) frm.push_back(8'(8'h40 + i));
        send_frame(0);
        frm.delete();
        for (int i = 0; i < 64; i++) frm.push_back(8'(8'hC0 - i));
        send_frame(0);
        wait_drain();
        check("ifg_exact", last_gap, IFG_LOW);

        // short frame: padded to MIN_LEN only when padding is built in
        frm.delete();
        for (int i = 0; i < 20; i++) frm.push_back(8'($urandom_range(1, 255)));
        send_frame(0);
        wait_drain();

        // reset in the middle of byte 10
        frm.delete();
        for (int i = 0; i < 30; i++) frm.push_back(8'(8'h80 + i));
        send_frame(0);
        seen = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk_phy);
            if (tx_en && !nib_phase && data_out == 8'h8A) begin seen = 1'b1; break; end
        end
        check("reached_byte10", int'(seen), 1);
        @(posedge clk_phy); #1;
        mon_hold = 1'b1;
        reset    = 1'b1;
        @(posedge clk_phy); #1;
        reset = 1'b0;
        check("midrst_tx_en", int'(tx_en), 0);
        check("midrst_data", int'(data_out), 0);
        check("midrst_full", int'(wr_full), 0);
        check("midrst_phase", int'(nib_phase), 0);
        exp_bytes.delete();
        exp_len.delete();
        any_tx = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk_phy);
            if (tx_en) any_tx = 1'b1;
        end
        check("midrst_silent", int'(any_tx), 0);
        @(posedge clk_phy); #1;
        mon_hold = 1'b0;
        frm.delete();
        for (int i = 0; i < 8; i++) frm.push_back(8'(8'h30 + i));
        send_frame(0);
        wait_drain();

        // randomized frames, including lengths 1, MIN_LEN and MIN_LEN-1
        for (int f = 0; f < 20; f++) begin
            len = (f == 0) ? 1 : (f == 1) ? MIN_LEN : (f == 2) ? MIN_LEN - 1 : $urandom_range(1, 100);
            frm.delete();
            for (int i = 0; i < len; i++) frm.push_back(8'($urandom_range(0, 255)));
            send_frame(2);
        end
        wait_drain();
        check("leftover_bytes", exp_bytes.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
